i2c_burst_read_ctrl: RTL
========================

Name: i2c_burst_read_ctrl

Overview:
Transaction sequencer for the I2C master byte engines: runs a complete register burst read (START, device-address write, register-pointer write, repeated START, device-address read, N data bytes, STOP). It drives the byte-write and byte-read engines through START/DONE handshakes. It generates START, repeated-START, STOP and master ACK/NACK bus conditions itself through open-drain enables. It sits between the sensor data-collection logic and the byte engines plus SDA/SCL pads.

Parameters:
DEV_ADDR, 7'h68, 7-bit slave address (write byte {DEV_ADDR,0}=8'hD0, read byte {DEV_ADDR,1}=8'hD1).
MAX_LEN, 16, maximum burst length in bytes.
HALF_PERIOD, 4, CLK cycles per bus-condition phase.
TIMEOUT, 1024, CLK cycles allowed for any byte-engine DONE.

Ports:
CLK  in  1  system clock
RST_N  in  1  reset
REQ  in  1  transaction request, sampled only in IDLE
REG_ADDR  in  8  first register to read
LEN  in  5  byte count, valid 1..MAX_LEN
BUSY  out  1  transaction in progress
DATA_OUT  out  8  received byte
DATA_VALID  out  1  one-cycle strobe per received byte
DONE  out  1  one-cycle end-of-transaction pulse
ERROR  out  1  status of last transaction
WR_START  out  1  write-engine start pulse
WR_BYTE  out  8  byte to write, stable from WR_START until WR_DONE
WR_DONE  in  1  write-engine done pulse
WR_ACK  in  1  slave ACK bit, valid with WR_DONE (0=ACK, 1=NACK)
RD_START  out  1  read-engine start pulse
RD_DONE  in  1  read-engine done pulse
RD_BYTE  in  8  received byte, valid with RD_DONE
BUS_OWN  out  1  1 = sequencer drives pads, 0 = active engine drives pads
SDA_OE  out  1  1 = pull SDA low
SCL_OE  out  1  1 = pull SCL low

Behaviour:
- Reset: RST_N is asynchronous, active-low; CLK is the clock. Reset forces state IDLE and all outputs 0, with SDA/SCL released. Reset mid-transaction behaves the same: bus released immediately, no DONE issued.
- All outputs are registered. A phase counter runs HALF_PERIOD cycles per phase. A timeout counter is cleared on each WR_START/RD_START.
- IDLE: on REQ, latch REG_ADDR and LEN, clear ERROR, and assert BUSY the next cycle. REQ while BUSY is ignored.
  - LEN=0 or LEN>MAX_LEN: go to FINISH with ERROR=1 and no bus activity.
- START_COND (BUS_OWN=1), two phases: SDA low with SCL high, then SCL low.
- SEND_DEV_W: WR_BYTE=8'hD0, pulse WR_START, wait for WR_DONE.
- SEND_REG: WR_BYTE=REG_ADDR, same handshake.
- RESTART (BUS_OWN=1), four phases: SDA released/SCL low; SCL released; SDA low; SCL low.
- SEND_DEV_R: WR_BYTE=8'hD1.
- READ_BYTE: pulse RD_START, wait for RD_DONE. The cycle after RD_DONE: DATA_OUT=RD_BYTE, DATA_VALID=1 for one cycle, remaining count decremented.
- MASTER_ACK (BUS_OWN=1), three phases with SCL low/high/low. SDA_OE=1 (ACK) if bytes remain; SDA_OE=0 (NACK) on the last byte.
  - Bytes remain -> READ_BYTE; last byte -> STOP_COND.
- STOP_COND (BUS_OWN=1), three phases: SDA low/SCL low; SCL released; SDA released.
- FINISH: DONE=1 for one cycle, BUSY=0 in the same cycle, then IDLE. ERROR holds until the next accepted REQ.
- NACK: WR_ACK=1 on any WR_DONE sets ERROR=1. The sequencer skips the remaining bytes, goes to STOP_COND, then FINISH.
- Timeout: no WR_DONE/RD_DONE within TIMEOUT cycles of a start sets ERROR=1, then STOP_COND, then FINISH.
- Engine DONE pulses outside their wait state are ignored.
- START pulses are exactly one cycle. Start-to-DONE in the same cycle is legal.

Test Plan:
1. REQ, REG_ADDR=8'h3B, LEN=6, all ACK, RD_BYTE=8'h10..8'h15 -> WR_BYTE sequence D0,3B,D1; six DATA_VALID strobes carrying 10..15; five ACKs then one NACK; STOP; DONE once, ERROR=0.
2. LEN=1, RD_BYTE=8'hA5 -> single DATA_VALID with 8'hA5, NACK immediately, STOP, DONE, ERROR=0.
3. WR_ACK=1 on the first WR_DONE -> no REG_ADDR write, no RD_START, STOP issued, DONE with ERROR=1. A new REQ clears ERROR.
4. LEN=0, then LEN=17 -> each gives DONE with ERROR=1, zero WR_START pulses, SDA_OE=SCL_OE=0 throughout.
5. RST_N low during the third READ_BYTE of a LEN=6 burst -> all outputs 0 immediately, no DONE. Next REQ runs a clean transaction.
6. RD_DONE withheld -> ERROR=1 after 1024 cycles, STOP generated, DONE pulse, BUSY=0.

Source files
------------

// File: rtl/i2c_burst_read_ctrl.sv
// i2c_burst_read_ctrl: I2C register burst-read sequencer driving byte engines and open-drain bus conditions
module i2c_burst_read_ctrl #(
  parameter logic [6:0] DEV_ADDR    = 7'h68,
  parameter int         MAX_LEN     = 16,
  parameter int         HALF_PERIOD = 4,
  parameter int         TIMEOUT     = 1024
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       REQ,
  input  logic [7:0] REG_ADDR,
  input  logic [4:0] LEN,
  output logic       BUSY,
  output logic [7:0] DATA_OUT,
  output logic       DATA_VALID,
  output logic       DONE,
  output logic       ERROR,
  output logic       WR_START,
  output logic [7:0] WR_BYTE,
  input  logic       WR_DONE,
  input  logic       WR_ACK,
  output logic       RD_START,
  input  logic       RD_DONE,
  input  logic [7:0] RD_BYTE,
  output logic       BUS_OWN,
  output logic       SDA_OE,
  output logic       SCL_OE
);
  localparam int CW = $clog2(HALF_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] L_CNT_END = CW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] L_TMO_END = TW'(TIMEOUT - 1);
  localparam logic [4:0]    L_MAX     = 5'(MAX_LEN);
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV_W, S_REG, S_RESTART, S_DEV_R, S_READ, S_MACK, S_STOP, S_FINISH
  } state_t;
  state_t        r_state, w_state;
  logic [1:0]    r_phase, w_phase;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [TW-1:0] r_tmo, w_tmo_n;
  logic          r_started, w_started;
  logic [7:0]    r_reg, w_reg;
  logic [4:0]    r_len, w_len;
  logic          r_busy, w_busy;
  logic [7:0]    r_data, w_data;
  logic          r_dv, w_dv;
  logic          r_done, w_done;
  logic          r_err, w_err;
  logic          r_wr_start, w_wr_start;
  logic [7:0]    r_wr_byte, w_wr_byte;
  logic          r_rd_start, w_rd_start;
  logic          r_own, w_own;
  logic          r_sda, w_sda;
  logic          r_scl, w_scl;
  logic          w_phase_end, w_step_done, w_tmo;
  logic [1:0]    w_last_phase;
  assign BUSY       = r_busy;
  assign DATA_OUT   = r_data;
  assign DATA_VALID = r_dv;
  assign DONE       = r_done;
  assign ERROR      = r_err;
  assign WR_START   = r_wr_start;
  assign WR_BYTE    = r_wr_byte;
  assign RD_START   = r_rd_start;
  assign BUS_OWN    = r_own;
  assign SDA_OE     = r_sda;
  assign SCL_OE     = r_scl;
  assign w_phase_end  = r_cnt == L_CNT_END;
  assign w_last_phase = r_state == S_START ? 2'd1 : r_state == S_RESTART ? 2'd3 : 2'd2;
  assign w_step_done  = w_phase_end && r_phase == w_last_phase;
  assign w_tmo        = r_tmo == L_TMO_END;
  // Register every next-state value so all outputs come straight from flops
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_started  <= 1'b0;
      r_reg      <= '0;
      r_len      <= '0;
      r_busy     <= 1'b0;
      r_data     <= '0;
      r_dv       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wr_start <= 1'b0;
      r_wr_byte  <= '0;
      r_rd_start <= 1'b0;
      r_own      <= 1'b0;
      r_sda      <= 1'b0;
      r_scl      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_phase    <= w_phase;
      r_cnt      <= w_cnt;
      r_tmo      <= w_tmo_n;
      r_started  <= w_started;
      r_reg      <= w_reg;
      r_len      <= w_len;
      r_busy     <= w_busy;
      r_data     <= w_data;
      r_dv       <= w_dv;
      r_done     <= w_done;
      r_err      <= w_err;
      r_wr_start <= w_wr_start;
      r_wr_byte  <= w_wr_byte;
      r_rd_start <= w_rd_start;
      r_own      <= w_own;
      r_sda      <= w_sda;
      r_scl      <= w_scl;
    end
  end
  // Next-state sequencing; bus levels are derived from the next state/phase so they register in step with it
  always_comb begin
    w_state    = r_state;
    w_phase    = '0;
    w_cnt      = '0;
    w_tmo_n    = r_started ? r_tmo + 1'b1 : '0;
    w_started  = r_started;
    w_reg      = r_reg;
    w_len      = r_len;
    w_busy     = r_busy;
    w_data     = r_data;
    w_err      = r_err;
    w_wr_byte  = r_wr_byte;
    w_dv       = 1'b0;
    w_done     = 1'b0;
    w_wr_start = 1'b0;
    w_rd_start = 1'b0;
    case (r_state)
      S_IDLE: if (REQ) begin
        w_reg   = REG_ADDR;
        w_len   = LEN;
        w_err   = LEN == 5'd0 || LEN > L_MAX;
        w_busy  = !w_err;
        w_done  = w_err;
        w_state = w_err ? S_FINISH : S_START;
      end
      S_START, S_RESTART, S_MACK, S_STOP: begin
        w_cnt   = w_phase_end ? '0 : r_cnt + 1'b1;
        w_phase = w_phase_end ? r_phase + 1'b1 : r_phase;
        if (w_step_done) begin
          w_phase = '0;
          w_state = r_state == S_START ? S_DEV_W :
                    r_state == S_RESTART ? S_DEV_R :
                    r_state == S_MACK ? (r_len != 5'd0 ? S_READ : S_STOP) : S_FINISH;
          w_done  = r_state == S_STOP;
          w_busy  = r_busy && r_state != S_STOP;
        end
      end
      S_DEV_W, S_REG, S_DEV_R: begin
        if (!r_started) begin
          w_wr_start = 1'b1;
          w_started  = 1'b1;
          w_tmo_n    = '0;
          w_wr_byte  = r_state == S_DEV_W ? {DEV_ADDR, 1'b0} : r_state == S_REG ? r_reg : {DEV_ADDR, 1'b1};
        end else if (WR_DONE || w_tmo) begin
          w_started = 1'b0;
          w_err     = !WR_DONE || WR_ACK;
          w_state   = w_err ? S_STOP : r_state == S_DEV_W ? S_REG : r_state == S_REG ? S_RESTART : S_READ;
        end
      end
      S_READ: begin
        if (!r_started) begin
          w_rd_start = 1'b1;
          w_started  = 1'b1;
          w_tmo_n    = '0;
        end else if (RD_DONE) begin
          w_started = 1'b0;
          w_data    = RD_BYTE;
          w_dv      = 1'b1;
          w_len     = r_len - 1'b1;
          w_state   = S_MACK;
        end else if (w_tmo) begin
          w_started = 1'b0;
          w_err     = 1'b1;
          w_state   = S_STOP;
        end
      end
      S_FINISH: w_state = S_IDLE;
      default:  w_state = S_IDLE;
    endcase
    w_own = w_state inside {S_START, S_RESTART, S_MACK, S_STOP};
    w_sda = w_state == S_START || (w_state == S_RESTART && w_phase[1]) ||
            (w_state == S_MACK && w_len != 5'd0) || (w_state == S_STOP && w_phase != 2'd2);
    w_scl = (w_state == S_START && w_phase == 2'd1) ||
            (w_state == S_RESTART && (w_phase == 2'd0 || w_phase == 2'd3)) ||
            (w_state == S_MACK && w_phase != 2'd1) || (w_state == S_STOP && w_phase == 2'd0);
  end
endmodule
